// File: rtl/lcd_hd44780_controller.sv
// HD44780 4-bit write-only controller: runs the power-on init sequence, then
// accepts one byte per request/ready handshake and strobes it out as two nibbles.
module lcd_hd44780_controller #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned T_POWERUP_US = 40000,
    parameter int unsigned T_EN_US      = 1,
    parameter int unsigned T_EXEC_US    = 50,
    parameter int unsigned T_LONG_US    = 2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       write_char,
    input  logic       write_cmd,
    output logic       ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_d
);

    localparam int unsigned US_CYC = CLK_HZ / 1_000_000;
    localparam logic [31:0] EN_CYC   = 32'(T_EN_US * US_CYC);
    localparam logic [31:0] EXEC_CYC = 32'(T_EXEC_US * US_CYC);
    localparam logic [31:0] LONG_CYC = 32'(T_LONG_US * US_CYC);
    localparam logic [31:0] PWR_CYC  = 32'(T_POWERUP_US * US_CYC);

    typedef enum logic [3:0] {
        POWERUP   = 4'd0,
        INIT_NIB  = 4'd1,
        INIT_WAIT = 4'd2,
        INIT_CMD  = 4'd3,
        IDLE      = 4'd4,
        NIB_SETUP = 4'd5,
        E_HIGH    = 4'd6,
        E_HOLD    = 4'd7,
        EXEC_WAIT = 4'd8
    } state_t;

    // Init items 0..3 are single nibbles (low 4 bits), 4..7 are full commands.
    function automatic logic [7:0] init_item(input logic [2:0] idx);
        logic [7:0] item;
        case (idx)
            3'd0, 3'd1, 3'd2: item = 8'h03;
            3'd3:             item = 8'h02;
            3'd4:             item = 8'h28;
            3'd5:             item = 8'h0C;
            3'd6:             item = 8'h06;
            3'd7:             item = 8'h01;
            default:          item = 8'h00;
        endcase
        return item;
    endfunction

    // Clear and home commands need the long execution time.
    function automatic logic wait_is_long(input logic rs, input logic [7:0] b);
        return (rs == 1'b0) && (b[7:2] == 6'd0) && (b != 8'd0);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  byte_q, byte_d;
    logic        rs_q, rs_d;
    logic        lo_q, lo_d;
    logic        single_q, single_d;
    logic        init_q, init_d;
    logic        long_q, long_d;
    logic        ready_q, ready_d;
    logic        e_q, e_d;
    logic [3:0]  d_q, d_d;

    logic [31:0] limit_s;
    logic        done_s;
    logic [2:0]  nxt_step_s;
    logic [7:0]  nxt_item_s;
    logic        acc_rs_s;

    assign nxt_step_s = step_q + 3'd1;
    assign nxt_item_s = init_item(nxt_step_s);
    assign acc_rs_s   = write_char & ~write_cmd;
    assign done_s     = (cnt_q == (limit_s - 32'd1));

    // Duration of the current state in clock cycles.
    always_comb begin
        limit_s = EN_CYC;
        case (state_q)
            POWERUP:                     limit_s = PWR_CYC;
            INIT_WAIT:                   limit_s = LONG_CYC;
            INIT_CMD, EXEC_WAIT:         limit_s = long_q ? LONG_CYC : EXEC_CYC;
            INIT_NIB, NIB_SETUP,
            E_HIGH, E_HOLD, IDLE:        limit_s = EN_CYC;
            default:                     limit_s = EN_CYC;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 32'd1;
        step_d   = step_q;
        byte_d   = byte_q;
        rs_d     = rs_q;
        lo_d     = lo_q;
        single_d = single_q;
        init_d   = init_q;
        long_d   = long_q;
        ready_d  = ready_q;
        e_d      = e_q;
        d_d      = d_q;
        case (state_q)
            POWERUP: begin
                if (done_s) begin
                    cnt_d    = 32'd0;
                    state_d  = INIT_NIB;
                    step_d   = 3'd0;
                    single_d = 1'b1;
                    init_d   = 1'b1;
                    rs_d     = 1'b0;
                    d_d      = 4'h3;
                end else begin
                    state_d = POWERUP;
                end
            end
            INIT_NIB, NIB_SETUP: begin
                if (done_s) begin
                    cnt_d   = 32'd0;
                    state_d = E_HIGH;
                    e_d     = 1'b1;
                end else begin
                    e_d = 1'b0;
                end
            end
            E_HIGH: begin
                if (done_s) begin
                    cnt_d   = 32'd0;
                    state_d = E_HOLD;
                    e_d     = 1'b0;
                end else begin
                    e_d = 1'b1;
                end
            end
            E_HOLD: begin
                if (done_s) begin
                    cnt_d = 32'd0;
                    if (single_q) begin
                        state_d = INIT_WAIT;
                    end else if (!lo_q) begin
                        state_d = NIB_SETUP;
                        lo_d    = 1'b1;
                        d_d     = byte_q[3:0];
                    end else begin
                        state_d = init_q ? INIT_CMD : EXEC_WAIT;
                    end
                end else begin
                    e_d = 1'b0;
                end
            end
            INIT_WAIT: begin
                if (done_s) begin
                    cnt_d  = 32'd0;
                    step_d = nxt_step_s;
                    if (step_q < 3'd3) begin
                        state_d  = INIT_NIB;
                        single_d = 1'b1;
                        d_d      = nxt_item_s[3:0];
                    end else begin
                        state_d  = NIB_SETUP;
                        single_d = 1'b0;
                        lo_d     = 1'b0;
                        byte_d   = nxt_item_s;
                        rs_d     = 1'b0;
                        long_d   = wait_is_long(1'b0, nxt_item_s);
                        d_d      = nxt_item_s[7:4];
                    end
                end else begin
                    state_d = INIT_WAIT;
                end
            end
            INIT_CMD: begin
                if (done_s) begin
                    cnt_d = 32'd0;
                    if (step_q == 3'd7) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        init_d  = 1'b0;
                    end else begin
                        step_d  = nxt_step_s;
                        state_d = NIB_SETUP;
                        lo_d    = 1'b0;
                        byte_d  = nxt_item_s;
                        rs_d    = 1'b0;
                        long_d  = wait_is_long(1'b0, nxt_item_s);
                        d_d     = nxt_item_s[7:4];
                    end
                end else begin
                    state_d = INIT_CMD;
                end
            end
            EXEC_WAIT: begin
                if (done_s) begin
                    cnt_d   = 32'd0;
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    state_d = EXEC_WAIT;
                end
            end
            IDLE: begin
                cnt_d = 32'd0;
                // A simultaneous char+cmd request resolves to a command.
                if (ready_q && (write_cmd || write_char)) begin
                    state_d  = NIB_SETUP;
                    ready_d  = 1'b0;
                    byte_d   = data_in;
                    rs_d     = acc_rs_s;
                    lo_d     = 1'b0;
                    single_d = 1'b0;
                    long_d   = wait_is_long(acc_rs_s, data_in);
                    d_d      = data_in[7:4];
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = POWERUP;
                cnt_d   = 32'd0;
                ready_d = 1'b0;
                e_d     = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= POWERUP;
            cnt_q    <= 32'd0;
            step_q   <= 3'd0;
            byte_q   <= 8'd0;
            rs_q     <= 1'b0;
            lo_q     <= 1'b0;
            single_q <= 1'b0;
            init_q   <= 1'b1;
            long_q   <= 1'b0;
            ready_q  <= 1'b0;
            e_q      <= 1'b0;
            d_q      <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            byte_q   <= byte_d;
            rs_q     <= rs_d;
            lo_q     <= lo_d;
            single_q <= single_d;
            init_q   <= init_d;
            long_q   <= long_d;
            ready_q  <= ready_d;
            e_q      <= e_d;
            d_q      <= d_d;
        end
    end

    assign ready  = ready_q;
    assign lcd_rs = rs_q;
    assign lcd_rw = 1'b0;
    assign lcd_e  = e_q;
    assign lcd_d  = d_q;

endmodule

// File: tb/tb_lcd_hd44780_controller.sv
// Bench for lcd_hd44780_controller: a transaction-level model predicts ready and
// the nibble stream seen on E falling edges; directed requests exercise it.
module tb_lcd_hd44780_controller;

    localparam int EN   = 1;
    localparam int EXEC = 5;
    localparam int LONG = 20;
    localparam int PWR  = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       write_char = 1'b0;
    logic       write_cmd = 1'b0;
    logic       ready, lcd_rs, lcd_rw, lcd_e;
    logic [3:0] lcd_d;

    lcd_hd44780_controller #(
        .CLK_HZ(1_000_000), .T_POWERUP_US(PWR), .T_EN_US(EN),
        .T_EXEC_US(EXEC), .T_LONG_US(LONG)
    ) dut (
        .clock(clock), .reset(reset), .data_in(data_in),
        .write_char(write_char), .write_cmd(write_cmd), .ready(ready),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int       tests = 0;
    int       fails = 0;
    int       ready_at = 0;
    int       rel = 0;
    int       e_falls = 0;
    int       e_len = 0;
    bit       check_en = 1'b0;
    bit       prev_e = 1'b0;
    int       exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int wait_of(input bit rs, input logic [7:0] b);
        return (!rs && b >= 8'd1 && b <= 8'd3) ? LONG : EXEC;
    endfunction

    task automatic push_byte(input bit rs, input logic [7:0] b);
        exp_q.push_back({27'd0, rs, b[7:4]});
        exp_q.push_back({27'd0, rs, b[3:0]});
    endtask

    // Model of the power-on sequence, started at the moment reset is released.
    task automatic model_init();
        logic [7:0] cmds [4];
        cmds = '{8'h28, 8'h0C, 8'h06, 8'h01};
        rel = cyc;
        exp_q.delete();
        exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(2);
        ready_at = cyc + PWR + 4 * (3 * EN + LONG);
        foreach (cmds[i]) begin
            push_byte(1'b0, cmds[i]);
            ready_at += 6 * EN + wait_of(1'b0, cmds[i]);
        end
    endtask

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clock);
        if (!check_en) begin
            prev_e = 1'b0;
            e_len  = 0;
        end else begin
            chk("ready", int'(ready), int'(cyc >= ready_at));
            chk("rw", int'(lcd_rw), 0);
            if (lcd_e) e_len++;
            if (prev_e && !lcd_e) begin
                e_falls++;
                chk("e_width", e_len, EN);
                e_len = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", int'({lcd_rs, lcd_d}), -1);
                end else begin
                    chk("nibble", int'({lcd_rs, lcd_d}), exp_q.pop_front());
                end
            end
            prev_e = lcd_e;
        end
    end

    task automatic measure_init(input string name);
        int f0;
        f0 = e_falls;
        for (int i = 0; i < 400 && !ready; i++) @(negedge clock);
        chk({name, "_ready_cycle"}, cyc - rel, 251);
        chk({name, "_e_pulses"}, e_falls - f0, 12);
        chk({name, "_queue"}, exp_q.size(), 0);
    endtask

    task automatic send(input bit cmd, input bit chr, input logic [7:0] b,
                        input int hold, input int exp_lat, input string name);
        int a, f0, lat;
        bit rs;
        do @(negedge clock); while (cyc < ready_at);
        #1;
        a  = cyc + 1;
        rs = chr & ~cmd;
        data_in = b; write_cmd = cmd; write_char = chr;
        push_byte(rs, b);
        ready_at = a + 6 * EN + wait_of(rs, b);
        f0 = e_falls;
        repeat (hold) @(negedge clock);
        #1;
        data_in = ~b; write_cmd = 1'b0; write_char = 1'b0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (ready) begin
                lat = cyc - a;
                break;
            end
            @(negedge clock);
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_pulses"}, e_falls - f0, 2);
        chk({name, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        int f0;
        bit seen;
        repeat (3) @(negedge clock);
        chk("rst_ready", int'(ready), 0);
        chk("rst_e", int'(lcd_e), 0);
        chk("rst_d", int'(lcd_d), 0);
        chk("rst_rs", int'(lcd_rs), 0);
        #1;
        reset = 1'b1;
        model_init();
        check_en = 1'b1;
        measure_init("init");

        send(1'b0, 1'b1, 8'h54, 1, 11, "char54");
        send(1'b1, 1'b0, 8'h01, 1, 26, "cmd01");
        send(1'b1, 1'b0, 8'hC0, 1, 11, "cmdC0");
        f0 = e_falls;
        send(1'b1, 1'b0, 8'h80, 5, 11, "held80");
        repeat (15) @(negedge clock);
        chk("held_single_write", e_falls - f0, 2);
        send(1'b1, 1'b1, 8'h48, 1, 11, "both48");
        repeat (15) @(negedge clock);
        chk("both_no_char", exp_q.size(), 0);

        // Reset while E is high.
        do @(negedge clock); while (cyc < ready_at);
        #1;
        data_in = 8'h41; write_char = 1'b1;
        push_byte(1'b1, 8'h41);
        ready_at = cyc + 1 + 6 * EN + EXEC;
        @(negedge clock); #1;
        write_char = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (lcd_e) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mid_e_seen", int'(seen), 1);
        #1;
        check_en = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_e", int'(lcd_e), 0);
        chk("mid_rst_ready", int'(ready), 0);
        chk("mid_rst_d", int'(lcd_d), 0);
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b1;
        model_init();
        check_en = 1'b1;
        measure_init("reinit");

        send(1'b0, 1'b1, 8'h2A, 1, 11, "char2A");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
